// File: rtl/stopwatch_display.sv
// Stopwatch display front end.
// Periodically snapshots the stopwatch time (hh:mm:ss.cc), checks that the
// snapshot is coherent with the live counter, converts each field to BCD with
// a sequential shift-add-3 engine and drives eight registered, active-low
// seven-segment digits. A lap pulse toggles a freeze that holds the digits
// while refreshes keep running in the background.
module stopwatch_display #(
    parameter int REFRESH_DIV = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] epoch,
    input  logic [7:0]  m_epoch,
    input  logic        lap,
    output logic [6:0]  hex7,
    output logic [6:0]  hex6,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        busy,
    output logic        frozen
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    // Segment pattern of the digit 0; also the power-on / reset display.
    localparam logic [6:0] SEG_ZERO = 7'h40;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CHECK,
        CONVERT,
        COMMIT
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Active-low segment patterns, bit6 = g ... bit0 = a.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;   // blank; unreachable with saturated BCD
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Refresh divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick;

    assign tick = (div_cnt_reg == DIV_LAST);

    // Free-running refresh divider, wraps after REFRESH_DIV-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_reg <= '0;
        end else if (tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Lap freeze
    // ------------------------------------------------------------------
    logic frozen_reg;

    // Each lap pulse flips the freeze; the commit gate sees the old value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frozen_reg <= 1'b0;
        end else if (lap) begin
            frozen_reg <= ~frozen_reg;
        end
    end

    assign frozen = frozen_reg;

    // ------------------------------------------------------------------
    // Snapshot and coherence check
    // ------------------------------------------------------------------
    logic [25:0] live_time;
    logic [25:0] snap_reg;
    logic        snap_match;
    logic        snap_load;
    logic        commit_en;
    logic        conv_last;

    assign live_time  = {epoch, m_epoch};
    assign snap_match = (snap_reg == live_time);

    // Snapshot is taken on the tick edge (so it is stable throughout SAMPLE)
    // and retaken on every CHECK cycle that finds the live time has moved.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_reg <= '0;
        end else if (snap_load) begin
            snap_reg <= live_time;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and control decode; ticks outside IDLE are simply ignored.
    always_comb begin
        state_next = state_reg;
        snap_load  = 1'b0;
        commit_en  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (tick) begin
                    snap_load  = 1'b1;
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (snap_match) begin
                    state_next = CONVERT;
                end else begin
                    snap_load = 1'b1;
                end
            end
            CONVERT: begin
                if (conv_last) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit_en  = ~frozen_reg;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential binary-to-BCD (shift-add-3), 8 cycles per field
    // ------------------------------------------------------------------
    logic [1:0]  field_reg;   // 0 hour, 1 minute, 2 second, 3 centisecond
    logic [2:0]  bit_reg;     // shift step within the current field
    logic [7:0]  bin_reg;
    logic [7:0]  bcd_reg;
    logic [7:0]  field_raw;
    logic [7:0]  field_sat;
    logic [7:0]  bin_cur;
    logic [7:0]  bcd_cur;
    logic [7:0]  bcd_adj;
    logic [15:0] dd_shift;
    logic [7:0]  bcd_shift;
    logic [7:0]  bin_shift;

    assign conv_last = (field_reg == 2'd3) && (bit_reg == 3'd7);

    // One shift-add-3 step; the first step of a field loads the saturated
    // field value instead of the running shift register.
    always_comb begin
        field_raw = 8'd0;
        case (field_reg)
            2'd0:    field_raw = {2'b00, snap_reg[25:20]};
            2'd1:    field_raw = {2'b00, snap_reg[19:14]};
            2'd2:    field_raw = {2'b00, snap_reg[13:8]};
            default: field_raw = snap_reg[7:0];
        endcase
        // Two digits per field: anything above 99 is clamped to 99.
        field_sat = (field_raw > 8'd99) ? 8'd99 : field_raw;

        bin_cur = (bit_reg == 3'd0) ? field_sat : bin_reg;
        bcd_cur = (bit_reg == 3'd0) ? 8'd0      : bcd_reg;

        bcd_adj[7:4] = (bcd_cur[7:4] >= 4'd5) ? bcd_cur[7:4] + 4'd3 : bcd_cur[7:4];
        bcd_adj[3:0] = (bcd_cur[3:0] >= 4'd5) ? bcd_cur[3:0] + 4'd3 : bcd_cur[3:0];

        dd_shift  = {bcd_adj, bin_cur} << 1;
        bcd_shift = dd_shift[15:8];
        bin_shift = dd_shift[7:0];
    end

    // Conversion sequencer; counters are parked at zero outside CONVERT so
    // each refresh starts at hour, step 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            field_reg <= '0;
            bit_reg   <= '0;
            bin_reg   <= '0;
            bcd_reg   <= '0;
        end else if (state_reg == CONVERT) begin
            bit_reg <= bit_reg + 1'b1;
            bin_reg <= bin_shift;
            bcd_reg <= bcd_shift;
            if (bit_reg == 3'd7) begin
                field_reg <= field_reg + 1'b1;
            end
        end else begin
            field_reg <= '0;
            bit_reg   <= '0;
        end
    end

    // Converted results, hour in the top byte down to centiseconds at the
    // bottom, so nibble k of conv_bcd is display digit k.
    logic [31:0] conv_bcd;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_field
            logic [7:0] result_reg;

            // Latch the field result on its eighth shift step.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    result_reg <= '0;
                end else if ((state_reg == CONVERT) && (bit_reg == 3'd7) &&
                             (field_reg == 2'(gi))) begin
                    result_reg <= bcd_shift;
                end
            end

            assign conv_bcd[(3-gi)*8 +: 8] = result_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered segment outputs
    // ------------------------------------------------------------------
    logic [55:0] seg_bus;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            logic [6:0] seg_reg;

            // Digit register, loaded only by an unfrozen COMMIT.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    seg_reg <= SEG_ZERO;
                end else if (commit_en) begin
                    seg_reg <= seg_encode(conv_bcd[gi*4 +: 4]);
                end
            end

            assign seg_bus[gi*7 +: 7] = seg_reg;
        end
    endgenerate

    assign hex0 = seg_bus[6:0];
    assign hex1 = seg_bus[13:7];
    assign hex2 = seg_bus[20:14];
    assign hex3 = seg_bus[27:21];
    assign hex4 = seg_bus[34:28];
    assign hex5 = seg_bus[41:35];
    assign hex6 = seg_bus[48:42];
    assign hex7 = seg_bus[55:49];

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 500000, clock cycles per display refresh tick (100 Hz at 50 MHz); legal values >= 40.
REQ-002 Port: clock  in  1  system clock, 50 MHz; all logic on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: epoch  in  18  {hour[17:12], minute[11:6], second[5:0]}, unsigned binary, from the stopwatch counter stage.
REQ-005 Port: m_epoch  in  8  centiseconds, unsigned binary, from the stopwatch counter stage.
REQ-006 Port: lap  in  1  one-cycle pulse, synchronous to clock; toggles the display freeze.
REQ-007 Port: hex7..hex0  out  7 each  active-low segments; bit6=g through bit0=a.
REQ-008 Port: busy  out  1  high while a refresh is in progress.
REQ-009 Port: frozen  out  1  high while the display is held (lap mode).

Function
REQ-010 The divider counts 0..REFRESH_DIV-1 and wraps; the block SHALL raise one tick cycle when the count equals REFRESH_DIV-1.
REQ-011 The FSM SHALL have states IDLE, SAMPLE, CHECK, CONVERT and COMMIT; busy SHALL be 1 in every state except IDLE.
REQ-012 IDLE->SAMPLE on tick; a tick in any other state SHALL be dropped, not queued.
REQ-013 SAMPLE SHALL capture epoch and m_epoch into snapshot registers, then go to CHECK.
REQ-014 CHECK SHALL compare the snapshot with the live inputs: if equal -> CONVERT, otherwise recapture and stay in CHECK; there is no retry limit.
REQ-015 CONVERT SHALL run sequential shift-add-3 binary-to-BCD, 8 cycles per field, fields in order hour, minute, second, centisecond: exactly 32 cycles, then COMMIT.
REQ-016 6-bit fields SHALL be zero-extended to 8 bits before conversion.
REQ-017 Any field with value > 99 SHALL saturate to BCD 99; m_epoch = 100 displays 99.
REQ-018 COMMIT SHALL load the 8 digit registers (hex7:6 hour, hex5:4 minute, hex3:2 second, hex1:0 centisecond; tens digit on the higher index) only when frozen = 0 in that cycle, then return to IDLE.
REQ-019 No-stall latency: tick at cycle T, SAMPLE at T+1, CHECK at T+2, CONVERT at T+3..T+34, COMMIT at T+35; new segments visible from T+36 and busy low from T+36.
REQ-020 Segment encoding (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; leading zeros are shown, never blanked.
REQ-021 A lap pulse SHALL toggle frozen in the following cycle, in any FSM state.
REQ-022 If a lap pulse and COMMIT coincide, the commit gate SHALL use the pre-toggle value of frozen.
REQ-023 While frozen = 1, refreshes SHALL still run (busy still pulses), but the hex outputs SHALL hold.
REQ-024 hex outputs SHALL be driven directly from registers, with no combinational path from the inputs.

Reset
REQ-025 Reset asserted SHALL immediately force: state IDLE, divider 0, snapshot 0, digit registers 0, all hex = 40, busy = 0, frozen = 0.
REQ-026 Reset asserted mid-refresh SHALL abort the refresh with no partial commit.
REQ-027 After reset release, the first tick SHALL occur REFRESH_DIV cycles later.

Verification (bench uses REFRESH_DIV=40)
REQ-028 Reset: assert reset at any time -> hex7..hex0 all 40, busy 0, frozen 0 within the same cycle.
REQ-029 Basic conversion: epoch = {1,23,45}, m_epoch = 67, held stable -> 36 cycles after the tick, hex7..hex0 = 40,79,24,30,19,12,02,78, and busy is high for exactly 35 cycles.
REQ-030 Saturation: m_epoch = 100, epoch = {0,59,59} -> hex1 = 10, hex1 = hex0 = 10, hex5..hex2 = 12,10,12,10.
REQ-031 Freeze: display showing 00:00:01.00, one lap pulse, then inputs change each tick for 3 ticks -> hex unchanged and frozen = 1; a second lap pulse -> the next COMMIT shows the current inputs.
REQ-032 Incoherent sample: change m_epoch from 5 to 6 in the SAMPLE cycle -> CHECK repeats once, COMMIT is at T+36, and the display shows centiseconds 06.
REQ-033 Abort: assert reset at T+20 during CONVERT, release at T+22 -> all hex 40, busy 0, and the next tick occurs at T+22+40.
